// File: rtl/dc_offset_remover.sv
// rtl/dc_offset_remover.sv - block-mean DC offset estimator and saturating remover
module dc_offset_remover #(
    parameter int LOG2_WIN = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_enable,
    input  logic       reset_not,
    input  logic       hold_est,
    input  logic [7:0] In1,
    output logic       ce_out,
    output logic [7:0] Out3,
    output logic       valid_out,
    output logic       settled
);

    localparam int AW = 8 + LOG2_WIN;
    localparam logic [LOG2_WIN-1:0] CNT_ONE  = {{(LOG2_WIN-1){1'b0}}, 1'b1};
    localparam logic [LOG2_WIN-1:0] CNT_LAST = {LOG2_WIN{1'b1}};

    typedef enum logic {
        FILL  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [LOG2_WIN-1:0] cnt_q, cnt_d;
    logic [7:0]          dc_est_q, dc_est_d;
    logic [7:0]          out_q, out_d;
    logic                valid_q;

    logic signed [8:0]    diff;
    logic [7:0]           diff_sat;
    logic signed [AW-1:0] acc_sum;
    logic                 win_end;

    // Sample minus current estimate at 9 bits, clamped back into 8-bit range
    always_comb begin
        diff = $signed({In1[7], In1}) - $signed({dc_est_q[7], dc_est_q});
        if (diff[8] != diff[7]) begin
            diff_sat = diff[8] ? 8'h80 : 8'h7f;
        end else begin
            diff_sat = diff[7:0];
        end
    end

    assign acc_sum = acc_q + $signed({{LOG2_WIN{In1[7]}}, In1});
    assign win_end = (cnt_q == CNT_LAST);

    // Next-state: strobe-qualified restart, accumulation and window-end estimate update
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dc_est_d = dc_est_q;
        out_d    = out_q;
        if (clk_enable) begin
            if (!reset_not) begin
                // Restart: the restart sample passes through untouched and is not accumulated
                state_d  = FILL;
                acc_d    = '0;
                cnt_d    = '0;
                dc_est_d = '0;
                out_d    = In1;
            end else begin
                out_d = diff_sat;
                if (win_end) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = TRACK;
                    if (!hold_est) begin
                        // Arithmetic shift of the full window sum is the floor of the mean
                        dc_est_d = acc_sum[LOG2_WIN +: 8];
                    end
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end
    end

    // State and datapath registers; valid tracks the strobe on every edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            acc_q    <= '0;
            cnt_q    <= '0;
            dc_est_q <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dc_est_q <= dc_est_d;
            out_q    <= out_d;
            valid_q  <= clk_enable;
        end
    end

    assign ce_out    = clk_enable;
    assign Out3      = out_q;
    assign valid_out = valid_q;
    assign settled   = (state_q == TRACK);

endmodule

// File: tb/tb_dc_offset_remover.sv
// tb/tb_dc_offset_remover.sv - scoreboard bench for dc_offset_remover
module tb_dc_offset_remover;

    localparam int LW  = 6;
    localparam int WIN = 1 << LW;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_enable;
    logic       reset_not;
    logic       hold_est;
    logic [7:0] In1;
    logic       ce_out;
    logic [7:0] Out3;
    logic       valid_out;
    logic       settled;

    int n_checks = 0;
    int n_errors = 0;

    int q_out[$];
    int q_set[$];

    int m_acc, m_cnt, m_dc, m_set;

    dc_offset_remover #(.LOG2_WIN(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .reset_not  (reset_not),
        .hold_est   (hold_est),
        .In1        (In1),
        .ce_out     (ce_out),
        .Out3       (Out3),
        .valid_out  (valid_out),
        .settled    (settled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int n);
        int q;
        q = a / n;
        if ((a % n != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_dc  = 0;
        m_set = 0;
    endtask

    // One clock: drive at negedge, predict, then compare after the rising edge
    task automatic step(input logic en, input logic rn, input logic hold, input int x);
        int e_out, sum, got_out, got_set;
        @(negedge clk);
        clk_enable = en;
        reset_not  = rn;
        hold_est   = hold;
        In1        = x[7:0];
        if (en) begin
            if (!rn) begin
                model_clear();
                e_out = x;
            end else begin
                e_out = sat8(x - m_dc);
                if (m_cnt == WIN - 1) begin
                    sum = m_acc + x;
                    if (!hold) m_dc = floor_div(sum, WIN);
                    m_acc = 0;
                    m_cnt = 0;
                    m_set = 1;
                end else begin
                    m_acc = m_acc + x;
                    m_cnt = m_cnt + 1;
                end
            end
            q_out.push_back(e_out);
            q_set.push_back(m_set);
        end
        #1;
        chk("ce_out", int'(ce_out), int'(en));
        @(posedge clk);
        #1;
        chk("valid_out", int'(valid_out), int'(en));
        if (valid_out) begin
            if (q_out.size() == 0) begin
                chk("scoreboard_underflow", 0, 1);
            end else begin
                got_out = $signed(Out3);
                got_set = int'(settled);
                chk("Out3", got_out, q_out.pop_front());
                chk("settled", got_set, q_set.pop_front());
            end
        end
    endtask

    task automatic feed(input int n, input int x, input logic hold);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, hold, x);
    endtask

    task automatic restart();
        step(1'b1, 1'b0, 1'b0, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        clk_enable = 1'b0;
        reset_not  = 1'b1;
        hold_est   = 1'b0;
        In1        = 8'h00;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_Out3", $signed(Out3), 0);
        chk("reset_valid", int'(valid_out), 0);
        chk("reset_settled", int'(settled), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Constant 20: passes through for a window, then removed
        feed(WIN + 4, 20, 1'b0);

        // Saturation both ways
        restart();
        feed(WIN, 100, 1'b0);
        feed(3, -100, 1'b0);
        restart();
        feed(WIN, -100, 1'b0);
        feed(3, 127, 1'b0);

        // Floor rounding: mean +0.5 -> 0, mean -0.5 -> -1
        restart();
        for (int i = 0; i < WIN; i++) step(1'b1, 1'b1, 1'b0, (i % 2 == 0) ? 1 : 0);
        feed(2, 0, 1'b0);
        restart();
        for (int i = 0; i < WIN; i++) step(1'b1, 1'b1, 1'b0, (i % 2 == 0) ? -1 : 0);
        feed(2, 0, 1'b0);

        // Sparse strobe, one cycle in three, with reset_not low on idle cycles
        restart();
        for (int i = 0; i < 3 * WIN + 9; i++) begin
            if (i % 3 == 0) step(1'b1, 1'b1, 1'b0, 10);
            else            step(1'b0, 1'b0, 1'b0, 77);
        end

        // Restart after settling needs a full fresh window
        restart();
        feed(WIN, 30, 1'b0);
        step(1'b1, 1'b0, 1'b0, 30);
        feed(WIN + 2, 30, 1'b0);

        // Hold estimate for a window, then release
        restart();
        feed(WIN, 30, 1'b0);
        feed(WIN, 50, 1'b1);
        feed(WIN, 50, 1'b0);
        feed(3, 50, 1'b0);
        feed(10, 50, 1'b0);

        // Async reset mid-window clears outputs without a clock edge
        @(negedge clk);
        clk_enable = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_Out3", $signed(Out3), 0);
        chk("async_valid", int'(valid_out), 0);
        chk("async_settled", int'(settled), 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        feed(WIN + 2, -7, 1'b0);

        chk("scoreboard_drained", q_out.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
